dpram_reader: RTL and testbench
===============================

# dpram_reader

Read-side controller for the `dpram` image/feature buffer in the recognition datapath. On a start command it walks a contiguous address range, drives the RAM read address, absorbs the RAM's one-cycle read latency, and presents the words as a valid/ready stream to the downstream recognition logic. Full throughput is one word per cycle under continuous `m_ready`, with no loss or duplication under backpressure.

## Interface
- `WIDTH`, 8: data word width; matches the RAM `WIDTH`.
- `DEPTH`, 10: address width; the RAM holds 2**DEPTH words.
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset_n` in 1: asynchronous active-low reset. Assertion clears all state immediately; release is sampled on `clock`.
- `start` in 1: command strobe, sampled only in IDLE.
- `base` in DEPTH: first address, sampled with `start`.
- `len` in DEPTH+1: number of words, 0..2**DEPTH, sampled with `start`.
- `rd_addr` out DEPTH: to RAM `rdaddress`.
- `rd_data` in WIDTH: from RAM `q`. Valid the cycle after `rd_addr` is presented.
- `m_valid` out 1; `m_ready` in 1; `m_data` out WIDTH; `m_last` out 1: output stream.
- `busy` out 1: high from the accepted `start` until `done`.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle reject pulse (see Configuration).

## Operation
- States:
  - IDLE: waits for a command.
  - RUN: issues reads and drains the buffer.
  - FIN: emits `done`, then returns to IDLE.
- IDLE + `start`:
  - `len`==0 goes to FIN. No beats are produced.
  - A rejected range pulses `err` and stays IDLE.
  - Otherwise goes to RUN. `addr` = `base`, issue counter = `len`, beat counter = `len`.
- Read issue rule:
  - A read issues in a cycle when issue counter > 0 and (buf_count + inflight − pop) < 2.
  - `pop` = `m_valid & m_ready`.
  - On issue, `rd_addr` holds `addr`, `addr` increments (DEPTH-bit), and the issue counter decrements.
  - `inflight` is set for exactly one cycle after each issue.
- Data buffer:
  - 2-entry FIFO.
  - When `inflight` is set, `rd_data` is written in that cycle.
  - `m_data` is the head entry. `m_valid` = buf_count != 0.
- `m_last` is high on the beat when the beat counter == 1.
  - Beat counter decrements on each pop.
  - A pop with `m_last` moves RUN to FIN.
- `rd_addr` holds its last value when not issuing. The RAM read has no side effects.
- `start` is ignored while `busy`.
- `m_data` / `m_last` are stable while `m_valid & !m_ready`.
- Reset mid-transfer:
  - The stream is abandoned. Buffer is emptied, state goes to IDLE, and no `done` is produced.
  - The downstream must discard the partial frame.

## Timing
- Reset values: `rd_addr`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- Latency from `start` high in cycle 0:
  - Cycle 1: `busy`=1 and `rd_addr`=`base`.
  - Cycle 2: `rd_data` valid and buffered.
  - Cycle 3: first `m_valid`.
- With `m_ready` held high, beats arrive on consecutive cycles. Last beat is in cycle 2+`len`.
- `done` is high in the cycle after the last handshake. `busy` falls in that same cycle.
- `len`==0: `done` in cycle 1, `busy` high only in cycle 1.
- `err` is high in cycle 1; `busy` stays 0.
- Backpressure: no more than 2 words are buffered or in flight at any time. When `m_ready` returns, output resumes the next edge with no bubble beyond the drain.

## Configuration
- `DPRAM_READER_WRAP_EN` defined:
  - `addr` wraps from 2**DEPTH−1 to 0.
  - Any `base`/`len` with `len` ≤ 2**DEPTH is accepted.
  - `err` is tied 0.
- Not defined:
  - A command with `base` + `len` > 2**DEPTH is rejected (`err` pulse, no reads, no beats).
  - `addr` never wraps.

## Test plan
- RAM preloaded with mem[i]=i; `base`=4, `len`=5, `m_ready`=1.
  - Required: beats 4,5,6,7,8 in cycles 3–7; `m_last` in cycle 7 only; `done` in cycle 8.
- Same preload; `base`=0, `len`=6; `m_ready` toggled 1,0,0,1,0,1…
  - Required: exactly 0..5 in order, no duplicates; `m_data` stable while stalled.
- `len`=0.
  - Required: `done` in cycle 1, `m_valid` never high.
- `base`=1020, `len`=8, DEPTH=10.
  - With macro: data 1020..1023 then 0..3.
  - Without macro: `err` in cycle 1, no `m_valid`, `busy`=0.
- `reset_n` pulled low after the 3rd beat of a `len`=10 run.
  - Required: all outputs go to reset values immediately; no `done`.
  - A new `start` with `base`=0, `len`=2 then produces 0,1.
- `start` re-asserted during RUN with `base`=100.
  - Required: ignored; the original stream completes unchanged.

Source files
------------

// File: rtl/dpram_reader.sv
// Read-side streamer for the dpram buffer: walks [base, base+len), hides the one-cycle RAM latency and
// presents words on a valid/ready stream. Optional DPRAM_READER_WRAP_EN lets the address wrap instead of rejecting.
module dpram_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 10
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [DEPTH-1:0] base,
    input  logic [DEPTH:0]   len,
    output logic [DEPTH-1:0] rd_addr,
    input  logic [WIDTH-1:0] rd_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]       state;
    logic [DEPTH-1:0] addr;
    logic [DEPTH-1:0] rd_addr_q;
    logic [DEPTH:0]   iss_cnt;
    logic [DEPTH:0]   beat_cnt;
    logic             inflight;
    logic [WIDTH-1:0] fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       fifo_cnt;
    logic             busy_q;
    logic             pop;
    logic             last_pop;
    logic             issue;
    logic             reject;
    logic             accept;
    logic [2:0]       occ;

`ifdef DPRAM_READER_WRAP_EN
    assign reject = 1'b0;
    assign err    = 1'b0;
`else
    logic             err_q;
    logic [DEPTH+1:0] range_end;

    assign range_end = (DEPTH+2)'(base) + (DEPTH+2)'(len);
    assign reject    = range_end > (DEPTH+2)'(2**DEPTH);
    assign err       = err_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= (state == S_IDLE) && start && reject;
    end
`endif

    assign pop      = m_valid & m_ready;
    assign last_pop = pop & m_last;
    assign accept   = (state == S_IDLE) && start && !reject;

    // Words buffered plus the one in flight, after this cycle's pop, must leave room for one more.
    assign occ   = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
    assign issue = (state == S_RUN) && (iss_cnt != '0) && (occ < 3'd2);

    assign rd_addr = issue ? addr : rd_addr_q;
    assign m_valid = fifo_cnt != 2'd0;
    assign m_data  = fifo_mem[rd_ptr];
    assign m_last  = m_valid && (beat_cnt == (DEPTH+1)'(1));
    assign busy    = busy_q;
    assign done    = state == S_FIN;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            addr      <= '0;
            rd_addr_q <= '0;
            iss_cnt   <= '0;
            beat_cnt  <= '0;
            inflight  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rd_addr_q <= rd_addr;
            inflight  <= issue;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state    <= (len == '0) ? S_FIN : S_RUN;
                        addr     <= base;
                        iss_cnt  <= len;
                        beat_cnt <= len;
                        busy_q   <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        addr    <= addr + 1'b1;
                        iss_cnt <= iss_cnt - 1'b1;
                    end
                    if (pop) beat_cnt <= beat_cnt - 1'b1;
                    if (last_pop) begin
                        state  <= S_FIN;
                        busy_q <= 1'b0;
                    end
                end
                S_FIN: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Two-entry skid FIFO; the head slot is never overwritten while it is being presented.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (inflight) begin
                fifo_mem[wr_ptr] <= rd_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + 2'(inflight) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_dpram_reader.sv
// Directed bench for dpram_reader against a RAM model preloaded with mem[i]=i (truncated to WIDTH).
module tb_dpram_reader;
    localparam int WIDTH = 8;
    localparam int DEPTH = 10;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic [DEPTH-1:0] base;
    logic [DEPTH:0]   len;
    logic [DEPTH-1:0] rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             busy;
    logic             done;
    logic             err;

    logic [WIDTH-1:0] mem [1<<DEPTH];
    int n_checks = 0;
    int n_fail   = 0;

    dpram_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .base(base), .len(len),
        .rd_addr(rd_addr), .rd_data(rd_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .busy(busy), .done(done), .err(err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) rd_data <= mem[rd_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; base = '0; len = '0; m_ready = 1'b1;
        #2;
        n_checks++;
        if (rd_addr !== '0) begin
            n_fail++; $display("FAIL reset_rd_addr: got %0h expected 0", rd_addr);
        end
        n_checks++;
        if ({m_valid, m_data, m_last, busy, done, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%0h l=%b b=%b dn=%b e=%b expected all 0",
                     m_valid, m_data, m_last, busy, done, err);
        end
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_basic();
        logic [3:0] exp_ctl;
        next_cycle();
        start = 1'b1; base = 10'd4; len = 11'd5; m_ready = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            start = 1'b0;
            sample();
            if (c == 1) begin
                n_checks++;
                if (rd_addr !== 10'd4) begin
                    n_fail++; $display("FAIL basic_rd_addr: got %0d expected 4", rd_addr);
                end
            end
            exp_ctl = {(c >= 3 && c <= 7), (c == 7), (c == 8), (c >= 1 && c <= 7)};
            n_checks++;
            if ({m_valid, m_last, done, busy} !== exp_ctl) begin
                n_fail++;
                $display("FAIL basic_ctl cycle %0d: got v/l/dn/b=%b expected %b",
                         c, {m_valid, m_last, done, busy}, exp_ctl);
            end
            if (c >= 3 && c <= 7) begin
                n_checks++;
                if (m_data !== 8'(c + 1)) begin
                    n_fail++; $display("FAIL basic_data cycle %0d: got %0d expected %0d", c, m_data, c + 1);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] got[$];
        logic [WIDTH-1:0] prev_d;
        logic             prev_last;
        bit               stall_prev;
        bit               seen_done;
        stall_prev = 1'b0; seen_done = 1'b0; prev_d = '0; prev_last = 1'b0;
        next_cycle();
        start = 1'b1; base = 10'd0; len = 11'd6; m_ready = 1'b1;
        for (int c = 1; c < 60 && !seen_done; c++) begin
            next_cycle();
            start = 1'b0;
            m_ready = (c % 6 == 0) || (c % 6 == 3) || (c % 6 == 5);
            sample();
            if (stall_prev) begin
                n_checks++;
                if ({m_valid, m_data, m_last} !== {1'b1, prev_d, prev_last}) begin
                    n_fail++;
                    $display("FAIL bp_stable cycle %0d: got v=%b d=%0d l=%b expected v=1 d=%0d l=%b",
                             c, m_valid, m_data, m_last, prev_d, prev_last);
                end
            end
            if (m_valid && m_ready) begin
                got.push_back(m_data);
                if (m_last) begin
                    n_checks++;
                    if (got.size() != 6) begin
                        n_fail++; $display("FAIL bp_last_pos: got last on beat %0d expected 6", got.size());
                    end
                end
            end
            stall_prev = m_valid && !m_ready;
            prev_d     = m_data;
            prev_last  = m_last;
            if (done) seen_done = 1'b1;
        end
        m_ready = 1'b1;
        n_checks++;
        if (!seen_done) begin
            n_fail++; $display("FAIL bp_done: got no done within 60 cycles expected done");
        end
        n_checks++;
        if (got.size() != 6) begin
            n_fail++; $display("FAIL bp_count: got %0d beats expected 6", got.size());
        end
        for (int i = 0; i < got.size() && i < 6; i++) begin
            n_checks++;
            if (got[i] !== 8'(i)) begin
                n_fail++; $display("FAIL bp_data beat %0d: got %0d expected %0d", i, got[i], i);
            end
        end
    endtask

    task automatic test_zero_len();
        next_cycle();
        start = 1'b1; base = 10'd7; len = 11'd0;
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            start = 1'b0;
            sample();
            n_checks++;
            if ({done, busy, m_valid} !== {(c == 1), (c == 1), 1'b0}) begin
                n_fail++;
                $display("FAIL zero_len cycle %0d: got dn/b/v=%b%b%b expected %b%b0",
                         c, done, busy, m_valid, (c == 1), (c == 1));
            end
        end
    endtask

    task automatic test_range();
        next_cycle();
        start = 1'b1; base = 10'd1020; len = 11'd8; m_ready = 1'b1;
`ifdef DPRAM_READER_WRAP_EN
        for (int c = 1; c <= 12; c++) begin
            next_cycle();
            start = 1'b0;
            sample();
            n_checks++;
            if ({m_valid, m_last, done, err} !== {(c >= 3 && c <= 10), (c == 10), (c == 11), 1'b0}) begin
                n_fail++;
                $display("FAIL wrap_ctl cycle %0d: got v/l/dn/e=%b%b%b%b", c, m_valid, m_last, done, err);
            end
            if (c >= 3 && c <= 10) begin
                n_checks++;
                if (m_data !== 8'((1020 + c - 3) % 1024)) begin
                    n_fail++;
                    $display("FAIL wrap_data cycle %0d: got %0d expected %0d", c, m_data, (1020 + c - 3) % 1024 % 256);
                end
            end
        end
`else
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            start = 1'b0;
            sample();
            n_checks++;
            if ({err, busy, m_valid, done} !== {(c == 1), 3'b000}) begin
                n_fail++;
                $display("FAIL reject cycle %0d: got e/b/v/dn=%b%b%b%b expected %b000",
                         c, err, busy, m_valid, done, (c == 1));
            end
        end
`endif
    endtask

    task automatic test_reset_mid();
        next_cycle();
        start = 1'b1; base = 10'd0; len = 11'd10; m_ready = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            start = 1'b0;
            sample();
            if (c >= 3) begin
                n_checks++;
                if ({m_valid, m_data} !== {1'b1, 8'(c - 3)}) begin
                    n_fail++; $display("FAIL rmid_pre cycle %0d: got v=%b d=%0d expected v=1 d=%0d",
                                       c, m_valid, m_data, c - 3);
                end
            end
        end
        next_cycle();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({rd_addr, m_valid, m_data, m_last, busy, done, err} !== '0) begin
            n_fail++;
            $display("FAIL rmid_reset: got a=%0d v=%b d=%0h l=%b b=%b dn=%b e=%b expected all 0",
                     rd_addr, m_valid, m_data, m_last, busy, done, err);
        end
        repeat (2) begin
            next_cycle();
            sample();
            n_checks++;
            if ({done, busy, m_valid} !== 3'b000) begin
                n_fail++; $display("FAIL rmid_hold: got dn/b/v=%b%b%b expected 000", done, busy, m_valid);
            end
        end
        next_cycle();
        reset_n = 1'b1;
        sample();
        n_checks++;
        if ({done, m_valid} !== 2'b00) begin
            n_fail++; $display("FAIL rmid_release: got dn/v=%b%b expected 00", done, m_valid);
        end
        next_cycle();
        start = 1'b1; base = 10'd0; len = 11'd2;
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            start = 1'b0;
            sample();
            n_checks++;
            if ({m_valid, m_last, done} !== {(c == 3 || c == 4), (c == 4), (c == 5)}) begin
                n_fail++; $display("FAIL rmid_restart_ctl cycle %0d: got v/l/dn=%b%b%b", c, m_valid, m_last, done);
            end
            if (c == 3 || c == 4) begin
                n_checks++;
                if (m_data !== 8'(c - 3)) begin
                    n_fail++; $display("FAIL rmid_restart_data cycle %0d: got %0d expected %0d", c, m_data, c - 3);
                end
            end
        end
    endtask

    task automatic test_start_during_run();
        logic [3:0] exp_ctl;
        next_cycle();
        start = 1'b1; base = 10'd10; len = 11'd4; m_ready = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            start = (c == 2);
            if (c == 2) begin
                base = 10'd100; len = 11'd3;
            end
            sample();
            exp_ctl = {(c >= 3 && c <= 6), (c == 6), (c == 7), (c >= 1 && c <= 6)};
            n_checks++;
            if ({m_valid, m_last, done, busy} !== exp_ctl) begin
                n_fail++;
                $display("FAIL restart_ctl cycle %0d: got v/l/dn/b=%b expected %b",
                         c, {m_valid, m_last, done, busy}, exp_ctl);
            end
            if (c >= 3 && c <= 6) begin
                n_checks++;
                if (m_data !== 8'(10 + c - 3)) begin
                    n_fail++; $display("FAIL restart_data cycle %0d: got %0d expected %0d", c, m_data, 10 + c - 3);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << DEPTH); i++) mem[i] = 8'(i);
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_range();
        test_reset_mid();
        test_start_during_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
